rsnn_param_loader: RTL and testbench
====================================

# rsnn_param_loader

Serial parameter loader for the 3-neuron recurrent SNN core, sitting directly upstream of the RSNN core. It deserialises the single-pin `data_in` stream, MSB first, into 8-bit words while `load_params` is high. Each word is written into a parameter register file covering input weights, recurrent weights, thresholds and leak values. The full file drives the core as a flat bus, and the block raises the `data_written` and `end_writing` status flags that go out on the chip pins.

## Interface
- `WORD_W`, 8, bits per parameter word.
- `NUM_WORDS`, 24, words per full load: 9 input weights, 9 recurrent weights, 3 thresholds, 3 leaks.
- `ADDR_W`, 5, address width; must satisfy 2^ADDR_W ≥ NUM_WORDS.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `system_enable`  in  1  global enable; when low, all state holds.
- `load_params`  in  1  load window; high = shift bits in.
- `data_in`  in  1  serial parameter bit, MSB first.
- `rd_addr`  in  ADDR_W  test readback address.
- `rd_data`  out  WORD_W  combinational readback of `mem[rd_addr]`; 0 when `rd_addr` ≥ NUM_WORDS.
- `params_flat`  out  NUM_WORDS*WORD_W  word i occupies bits [i*WORD_W +: WORD_W].
- `params_valid`  out  1  a complete load has finished since the last load start.
- `data_written`  out  1  one-cycle pulse per word committed.
- `end_writing`  out  1  full load complete; held while in DONE.

## Operation
- The state machine has three states: IDLE, SHIFT and DONE.
- All transitions and samples are qualified by `system_enable`. When `system_enable` is 0, nothing changes and `data_written` is forced to 0.
- **IDLE, `load_params` = 1:** sample `data_in` into the shift register, set `bit_cnt` = 1, set `word_addr` = 0, clear `params_valid`, then go to SHIFT.
- **SHIFT, `load_params` = 1:**
  - The shift register takes `{sr[WORD_W-2:0], data_in}` each cycle and `bit_cnt` increments.
  - On the WORD_W-th bit, write `{sr[WORD_W-2:0], data_in}` to `mem[word_addr]`, pulse `data_written`, clear `bit_cnt` and increment `word_addr`.
  - If that word was at `word_addr` = NUM_WORDS-1, go to DONE and set `params_valid` and `end_writing`.
- **SHIFT, `load_params` = 0 (abort):**
  - The partial word is discarded and `bit_cnt` is cleared.
  - Words already written remain in `mem`, but `params_valid` stays 0.
  - The state returns to IDLE.
- **DONE:**
  - `data_in` is ignored and `mem` is frozen.
  - When `load_params` goes to 0, return to IDLE and clear `end_writing`; `params_valid` stays 1.
- `params_flat` is driven directly from `mem` and updates word-by-word during a load. The consumer gates its use of the bus with `params_valid`.
- **Reset values:** state IDLE; `mem`, shift register, `bit_cnt` and `word_addr` all 0; `params_valid`, `data_written` and `end_writing` all 0.

## Timing
- One bit is accepted per enabled rising edge while `load_params` = 1, including the edge that leaves IDLE.
- **Word commit:**
  - The 8th bit's edge writes `mem`.
  - `data_written` is high for exactly the following cycle.
  - `rd_data` and `params_flat` show the new word in that same cycle.
- **Full load:**
  - A full load takes 192 enabled edges.
  - `end_writing` and `params_valid` rise on the edge that commits word 23, together with the last `data_written`.
- Deasserting `load_params` exactly on the edge after word 23 commits goes DONE → IDLE one edge later; `end_writing` is therefore high for at least one cycle.
- An asynchronous `reset` mid-load returns immediately to IDLE with `mem` cleared.
- `rd_data` has zero latency; it is combinational from `rd_addr`.

## Structure
- The shared package `rsnn_pkg` holds:
  - `NUM_NEURONS` = 3, `WORD_W`, `NUM_WORDS`;
  - address-map constants `W_IN_BASE` = 0, `W_REC_BASE` = 9, `THR_BASE` = 18, `LEAK_BASE` = 21;
  - the loader state enum.
- One sub-module, `rsnn_param_regfile`, holds the NUM_WORDS × WORD_W register array. It has a write port (`we`, `waddr`, `wdata`), the asynchronous reset clear, the flat output and the combinational read port.
- The FSM, shift register and counters live in `rsnn_param_loader`.

## Test plan
- **Reset:** assert `reset` mid-cycle → every output is 0 immediately; `rd_data` reads 0 at every address.
- **Full load:** stream words `8'hA0+i` (i = 0..23), MSB first. Expect:
  - 24 `data_written` pulses, each 8 cycles apart;
  - `rd_addr` = 18 returns `8'hB2`;
  - `end_writing` and `params_valid` high after the 192nd bit;
  - `params_flat[7:0]` = `8'hA0`.
- **Abort:** drop `load_params` after 3 words plus 5 bits. Expect exactly 3 pulses, `mem[3]` = 0, `params_valid` = 0, state back in IDLE. A restart then rewrites from address 0.
- **Enable gating:** hold `system_enable` = 0 for 10 cycles in the middle of word 2. Expect no sampling, no `data_written` pulse, and the word completes correctly once enable returns.
- **Reload:** after a complete load, raise `load_params` again. `params_valid` must fall on the first edge, and new values must overwrite the old ones.
- **DONE hold:** keep `load_params` high with `data_in` toggling for 20 cycles after completion. `mem` must be unchanged and `end_writing` must stay 1.

Source files
------------

// File: rtl/rsnn_pkg.sv
// Shared constants, address map and loader state encoding for the 3-neuron RSNN core.
package rsnn_pkg;

  localparam int NUM_NEURONS = 3;
  localparam int WORD_W      = 8;
  localparam int NUM_WORDS   = 24;
  localparam int ADDR_W      = 5;
  localparam int CNT_W       = $clog2(WORD_W);
  localparam int FLAT_W      = NUM_WORDS * WORD_W;

  // Parameter address map: input weights, recurrent weights, thresholds, leaks.
  localparam int W_IN_BASE  = 0;
  localparam int W_REC_BASE = 9;
  localparam int THR_BASE   = 18;
  localparam int LEAK_BASE  = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] sr,
                                                 input logic              bit_in);
    return {sr[WORD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/rsnn_param_loader_if.sv
// Control, serial-data, readback and status bundle between the loader and its environment.
interface rsnn_param_loader_if;
  import rsnn_pkg::*;

  logic                  system_enable;
  logic                  load_params;
  logic                  data_in;
  logic [ADDR_W-1:0]     rd_addr;
  logic [WORD_W-1:0]     rd_data;
  logic [FLAT_W-1:0]     params_flat;
  logic                  params_valid;
  logic                  data_written;
  logic                  end_writing;

  modport master (
    output system_enable, load_params, data_in, rd_addr,
    input  rd_data, params_flat, params_valid, data_written, end_writing
  );

  modport slave (
    input  system_enable, load_params, data_in, rd_addr,
    output rd_data, params_flat, params_valid, data_written, end_writing
  );

endinterface

// File: rtl/rsnn_param_regfile.sv
// NUM_WORDS x WORD_W parameter store: one write port, a flat bus view and an
// unregistered readback port that returns 0 beyond the last word.
module rsnn_param_regfile
  import rsnn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WORD_W-1:0]  rd_data,
  output logic [FLAT_W-1:0]  params_flat
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] mem_d [NUM_WORDS];

  // Next memory contents: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr < ADDR_W'(NUM_WORDS))) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Readback mux with out-of-range addresses reading as zero.
  always_comb begin
    rd_data = {WORD_W{1'b0}};
    if (rd_addr < ADDR_W'(NUM_WORDS)) begin
      rd_data = mem_q[rd_addr];
    end else begin
      rd_data = {WORD_W{1'b0}};
    end
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_flat
    assign params_flat[i*WORD_W +: WORD_W] = mem_q[i];
  end

endmodule

// File: rtl/rsnn_param_loader.sv
// Serial MSB-first parameter loader: deserialises data_in into words and commits
// them in address order into the parameter register file while load_params is high.
module rsnn_param_loader
  import rsnn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rsnn_param_loader_if.slave bus
);

  loader_state_e     state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              params_valid_q, params_valid_d;
  logic              data_written_q, data_written_d;
  logic              end_writing_q, end_writing_d;

  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] sr_shifted;
  logic              last_bit;
  logic              last_word;

  assign sr_shifted = shift_in(sr_q, bus.data_in);
  assign last_bit   = (bit_cnt_q == CNT_W'(WORD_W - 1));
  assign last_word  = (word_addr_q == ADDR_W'(NUM_WORDS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; everything holds while system_enable is low.
  always_comb begin
    state_d = state_q;
    if (bus.system_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_params) state_d = ST_SHIFT;
          else                 state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (!bus.load_params)           state_d = ST_IDLE;
          else if (last_bit && last_word) state_d = ST_DONE;
          else                            state_d = ST_SHIFT;
        end
        ST_DONE: begin
          if (!bus.load_params) state_d = ST_IDLE;
          else                  state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and status next values, plus the register-file write strobe.
  always_comb begin
    sr_d           = sr_q;
    bit_cnt_d      = bit_cnt_q;
    word_addr_d    = word_addr_q;
    params_valid_d = params_valid_q;
    data_written_d = 1'b0;
    end_writing_d  = end_writing_q;
    wr_en          = 1'b0;
    wr_data        = sr_shifted;
    if (bus.system_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_params) begin
            sr_d           = shift_in({WORD_W{1'b0}}, bus.data_in);
            bit_cnt_d      = CNT_W'(1);
            word_addr_d    = {ADDR_W{1'b0}};
            params_valid_d = 1'b0;
          end else begin
            sr_d = sr_q;
          end
        end
        ST_SHIFT: begin
          if (!bus.load_params) begin
            bit_cnt_d = {CNT_W{1'b0}};
          end else if (last_bit) begin
            sr_d           = sr_shifted;
            wr_en          = 1'b1;
            data_written_d = 1'b1;
            bit_cnt_d      = {CNT_W{1'b0}};
            word_addr_d    = word_addr_q + ADDR_W'(1);
            if (last_word) begin
              params_valid_d = 1'b1;
              end_writing_d  = 1'b1;
            end else begin
              end_writing_d  = end_writing_q;
            end
          end else begin
            sr_d      = sr_shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!bus.load_params) end_writing_d = 1'b0;
          else                  end_writing_d = end_writing_q;
        end
        default: begin
          bit_cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      data_written_d = 1'b0;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q           <= {WORD_W{1'b0}};
      bit_cnt_q      <= {CNT_W{1'b0}};
      word_addr_q    <= {ADDR_W{1'b0}};
      params_valid_q <= 1'b0;
      data_written_q <= 1'b0;
      end_writing_q  <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      word_addr_q    <= word_addr_d;
      params_valid_q <= params_valid_d;
      data_written_q <= data_written_d;
      end_writing_q  <= end_writing_d;
    end
  end

  assign bus.params_valid = params_valid_q;
  assign bus.data_written = data_written_q;
  assign bus.end_writing  = end_writing_q;

  rsnn_param_regfile u_regfile (
    .clk         (clk),
    .reset       (reset),
    .we          (wr_en),
    .waddr       (word_addr_q),
    .wdata       (wr_data),
    .rd_addr     (bus.rd_addr),
    .rd_data     (bus.rd_data),
    .params_flat (bus.params_flat)
  );

endmodule

// File: tb/tb_rsnn_param_loader.sv
// Directed self-checking bench for rsnn_param_loader: reset, abort, enable gating,
// full load, DONE hold, reload and asynchronous reset during a load.
module tb_rsnn_param_loader;
  import rsnn_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   dw_cnt;
  int   gap_err;
  int   last_dw;
  int   cyc;
  logic [FLAT_W-1:0] exp_flat;

  rsnn_param_loader_if bus ();

  rsnn_param_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts data_written pulses and flags spacing other than 8 cycles.
  always @(negedge clk) begin
    if (bus.data_written === 1'b1) begin
      dw_cnt = dw_cnt + 1;
      if (last_dw >= 0 && (cyc - last_dw) != 8) gap_err = gap_err + 1;
      last_dw = cyc;
    end
    cyc = cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.data_in     = b;
    bus.load_params = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) send_bit(w[k]);
  endtask

  task automatic read_check(input logic [4:0] a, input logic [7:0] exp, input string nm);
    bus.rd_addr = a;
    #1;
    checks++;
    if (bus.rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_data[%0d] got %h expected %h", nm, a, bus.rd_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.system_enable = 1'b1;
    bus.load_params   = 1'b0;
    bus.data_in       = 1'b0;
    bus.rd_addr       = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.params_valid, bus.data_written, bus.end_writing} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000",
               {bus.params_valid, bus.data_written, bus.end_writing});
    end
    checks++;
    if (bus.params_flat !== {FLAT_W{1'b0}}) begin
      errors++;
      $display("FAIL reset_flat: got %h expected 0", bus.params_flat);
    end
    for (int a = 0; a < 32; a++) read_check(5'(a), 8'h00, "reset_rd");
  endtask

  task automatic test_abort();
    int base;
    base = dw_cnt;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    for (int k = 7; k >= 3; k--) send_bit(k[0]);
    bus.load_params = 1'b0;
    tick();
    checks++;
    if (dw_cnt - base !== 3) begin
      errors++;
      $display("FAIL abort_pulses: got %0d expected 3", dw_cnt - base);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL abort_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    checks++;
    if (bus.params_valid !== 1'b0 || bus.end_writing !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: pv %b ew %b expected 0 0", bus.params_valid, bus.end_writing);
    end
    read_check(5'd3, 8'h00, "abort_mem3");
    read_check(5'd2, 8'h33, "abort_mem2");
    send_word(8'h44);
    read_check(5'd0, 8'h44, "restart_mem0");
    read_check(5'd1, 8'h22, "restart_mem1");
    bus.load_params = 1'b0;
    tick();
  endtask

  task automatic test_enable_gating();
    int base;
    base = dw_cnt;
    send_word(8'hC1);
    send_word(8'hC2);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.system_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.data_in = k[0];
      tick();
      checks++;
      if (bus.data_written !== 1'b0) begin
        errors++;
        $display("FAIL gate_dw: cycle %0d got %b expected 0", k, bus.data_written);
      end
    end
    checks++;
    if (dw_cnt - base !== 2) begin
      errors++;
      $display("FAIL gate_pulses: got %0d expected 2", dw_cnt - base);
    end
    bus.system_enable = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (bus.data_written !== 1'b1) begin
      errors++;
      $display("FAIL gate_commit_dw: got %b expected 1", bus.data_written);
    end
    read_check(5'd2, 8'hC3, "gate_word2");
    read_check(5'd1, 8'hC2, "gate_word1");
    bus.load_params = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    int base;
    int gbase;
    base    = dw_cnt;
    gbase   = gap_err;
    last_dw = -1;
    for (int i = 0; i < 24; i++) begin
      send_word(8'hA0 + 8'(i));
      exp_flat[i*8 +: 8] = 8'hA0 + 8'(i);
    end
    checks++;
    if ({bus.end_writing, bus.params_valid, bus.data_written} !== 3'b111) begin
      errors++;
      $display("FAIL full_flags: ew/pv/dw got %b expected 111",
               {bus.end_writing, bus.params_valid, bus.data_written});
    end
    @(negedge clk);
    #1;
    checks++;
    if (dw_cnt - base !== 24) begin
      errors++;
      $display("FAIL full_pulses: got %0d expected 24", dw_cnt - base);
    end
    checks++;
    if (gap_err - gbase !== 0) begin
      errors++;
      $display("FAIL full_spacing: got %0d bad gaps expected 0", gap_err - gbase);
    end
    read_check(5'd18, 8'hB2, "full_thr0");
    checks++;
    if (bus.params_flat[7:0] !== 8'hA0) begin
      errors++;
      $display("FAIL full_flat0: got %h expected a0", bus.params_flat[7:0]);
    end
    checks++;
    if (bus.params_flat !== exp_flat) begin
      errors++;
      $display("FAIL full_flat: got %h expected %h", bus.params_flat, exp_flat);
    end
  endtask

  task automatic test_done_hold();
    for (int k = 0; k < 20; k++) begin
      send_bit(k[0]);
      checks++;
      if (bus.end_writing !== 1'b1 || bus.data_written !== 1'b0) begin
        errors++;
        $display("FAIL hold_status: cycle %0d ew %b dw %b expected 1 0",
                 k, bus.end_writing, bus.data_written);
      end
    end
    checks++;
    if (bus.params_flat !== exp_flat) begin
      errors++;
      $display("FAIL hold_mem: got %h expected %h", bus.params_flat, exp_flat);
    end
    bus.load_params = 1'b0;
    tick();
    checks++;
    if (bus.end_writing !== 1'b0 || bus.params_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_exit: ew %b pv %b expected 0 1", bus.end_writing, bus.params_valid);
    end
  endtask

  task automatic test_reload();
    logic [7:0] w;
    w = 8'h10;
    send_bit(w[7]);
    checks++;
    if (bus.params_valid !== 1'b0) begin
      errors++;
      $display("FAIL reload_pv_fall: got %b expected 0", bus.params_valid);
    end
    for (int k = 6; k >= 0; k--) send_bit(w[k]);
    exp_flat[7:0] = 8'h10;
    for (int i = 1; i < 24; i++) begin
      send_word(8'h10 + 8'(i));
      exp_flat[i*8 +: 8] = 8'h10 + 8'(i);
    end
    checks++;
    if (bus.params_valid !== 1'b1 || bus.end_writing !== 1'b1) begin
      errors++;
      $display("FAIL reload_done: pv %b ew %b expected 1 1", bus.params_valid, bus.end_writing);
    end
    checks++;
    if (bus.params_flat !== exp_flat) begin
      errors++;
      $display("FAIL reload_flat: got %h expected %h", bus.params_flat, exp_flat);
    end
    read_check(5'd23, 8'h27, "reload_leak2");
    read_check(5'd24, 8'h00, "reload_oob");
    bus.load_params = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    send_word(8'h5A);
    send_word(8'h3C);
    bus.rd_addr = 5'd1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.params_valid, bus.data_written, bus.end_writing} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b expected 000",
               {bus.params_valid, bus.data_written, bus.end_writing});
    end
    checks++;
    if (bus.params_flat !== {FLAT_W{1'b0}} || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_mem: flat %h rd %h expected 0 0", bus.params_flat, bus.rd_data);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    bus.load_params = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    dw_cnt  = 0;
    gap_err = 0;
    last_dw = -1;
    cyc     = 0;
    exp_flat = {FLAT_W{1'b0}};
    test_reset();
    test_abort();
    test_enable_gating();
    test_full_load();
    test_done_hold();
    test_reload();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
